exe_pipe_unit: RTL and testbench
================================

// Module: exe_pipe_unit
// PURPOSE
// Single-issue execute stage: decodes a uopc micro-op and packed immediate, then computes the ALU result, branch
// outcome/target and link value. Valid/ready in and out; one-entry output register. Optional iterative shifter (multi-cycle).
// Sits between issue/RRD and writeback; branch outputs feed fetch redirect.
// PARAMETERS
// XLEN          32  datapath width (32 only for rv32i; shamt = operand[4:0])
// TAG_W         6   width of opaque tag carried in->out
// SHIFT_SERIAL  0   0: single-cycle barrel shift; 1: iterative shift, SHIFT_STEP bits/cycle
// SHIFT_STEP    4   bits shifted per iteration when SHIFT_SERIAL=1 (1..16)
// PORTS
// clk            in   1      clock
// rst            in   1      synchronous, active-high reset
// flush          in   1      synchronous kill of in-flight and held op
// in_valid       in   1      operation offered
// in_ready       out  1      stage accepts this cycle
// in_uop         in   uopc   micro-op (uopc::*)
// in_imm_type    in   immt   immt::i/u/j/b
// in_packed_imm  in   20     packed immediate
// in_pc          in   XLEN   op PC
// in_rs1/in_rs2  in   XLEN   source operands
// in_tag         in   TAG_W  opaque tag
// out_valid      out  1      result held
// out_ready      in   1      consumer takes result
// out_result     out  XLEN   ALU result / link value
// out_br_valid   out  1      op was branch/jalr
// out_br_taken   out  1      redirect required
// out_br_target  out  XLEN   redirect PC
// out_tag        out  TAG_W  tag of held result
// BEHAVIOUR
// - Reset (and reset mid-shift): state IDLE, out_valid=0, all out_* data = 0; reset beats flush and handshakes.
// - in_ready = (state==IDLE) && !flush && (!out_valid || out_ready). Accept = in_valid && in_ready.
// - Imm decode (s=packed[19]): imm[31]=s; [30:20]=u?p[18:8]:{s}; [19:12]=(u|j)?p[7:0]:{s};
//   [11]=u?0:(j|b)?p[8]:s; [10:1]=u?0:p[18:9]; [0]=i?p[8]:0.
// - ops: lui 0+imm; auipc pc+imm; imm forms rs1 op imm; reg forms rs1 op rs2; slt/sltu signed/unsigned -> 0/1.
//   Shift amount = opr2[4:0]. Unknown uop -> result=imm, no branch.
// - beq..bgeu: target=pc+imm, taken per compare (blt/bge signed, bltu/bgeu unsigned), result=target, br_valid=1.
// - jalr: result=pc+4, target=(rs1+imm)&~1, taken=1, br_valid=1. Arithmetic mod 2^XLEN, no overflow flags.
// - Non-shift ops (or SHIFT_SERIAL=0): output registered on accept; out_valid the next cycle (latency 1).
// - FSM IDLE/SHIFT. Serial shift, shamt!=0: IDLE->SHIFT, latch operand/shamt/tag, out_valid unchanged.
//   Each SHIFT cycle shift by min(SHIFT_STEP,rem), rem-=step; at rem==0 load output, ->IDLE.
//   Latency = ceil(shamt/SHIFT_STEP)+1. shamt==0 behaves as single-cycle.
// - SHIFT entered only when out reg is free or drained that cycle; at completion out reg is always free.
// - Hold: while out_valid && !out_ready, all out_* stable. Accept + drain same cycle: new result replaces old, no bubble.
// - flush: next cycle out_valid=0; FSM->IDLE, shift aborted; flush-cycle input not accepted; out_* data may keep stale values.
// - Full throughput: one op/cycle when out_ready=1 and no serial shifts.
// TESTING
// 1 addi rs1=5, i-imm packed p[19]=1 (imm=-1 forms) -> out_result=4, latency 1, br_valid=0.
// 2 lui packed_imm=20'hABCDE, immt::u -> out_result=32'hABCDE000; auipc pc=0x100 -> 0xABCDE100.
// 3 SHIFT_SERIAL=1,STEP=4: sra rs1=0x80000000, rs2=31 -> 0xFFFFFFFF after 9 cycles; in_ready=0 meanwhile.
// 4 bltu rs1=1, rs2=0xFFFFFFFF, pc=0x40, imm=8 -> taken=1, target=0x48; blt same operands -> taken=0.
// 5 jalr rs1=0x1001, imm=2, pc=0x200 -> target=0x1002, result=0x204, taken=1.
// 6 out_ready=0 for 3 cycles with op held -> out_* stable, in_ready=0; flush mid-shift -> out_valid=0 next cycle, IDLE.

Source files
------------

// File: rtl/exe_pipe_unit.sv
// Execute stage: immediate decode, ALU, branch resolve and link value into a one-entry output register.
// Latency 1 (serial shifts: ceil(shamt/SHIFT_STEP)+1); in_ready low while shifting or while a held result is not taken.
module exe_pipe_unit #(
    parameter int XLEN         = 32,
    parameter int TAG_W        = 6,
    parameter int SHIFT_SERIAL = 0,
    parameter int SHIFT_STEP   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_uop,
    input  logic [1:0]       in_imm_type,
    input  logic [19:0]      in_packed_imm,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic             out_br_valid,
    output logic             out_br_taken,
    output logic [XLEN-1:0]  out_br_target,
    output logic [TAG_W-1:0] out_tag
);
    localparam logic [4:0] U_LUI  = 5'd0,  U_AUIPC = 5'd1,  U_ADDI = 5'd2,  U_SLTI = 5'd3;
    localparam logic [4:0] U_SLTIU = 5'd4, U_XORI  = 5'd5,  U_ORI  = 5'd6,  U_ANDI = 5'd7;
    localparam logic [4:0] U_SLLI = 5'd8,  U_SRLI  = 5'd9,  U_SRAI = 5'd10, U_ADD  = 5'd11;
    localparam logic [4:0] U_SUB  = 5'd12, U_SLL   = 5'd13, U_SLT  = 5'd14, U_SLTU = 5'd15;
    localparam logic [4:0] U_XOR  = 5'd16, U_SRL   = 5'd17, U_SRA  = 5'd18, U_OR   = 5'd19;
    localparam logic [4:0] U_AND  = 5'd20, U_BEQ   = 5'd21, U_BNE  = 5'd22, U_BLT  = 5'd23;
    localparam logic [4:0] U_BGE  = 5'd24, U_BLTU  = 5'd25, U_BGEU = 5'd26, U_JALR = 5'd27;

    localparam logic [1:0] IT_I = 2'd0, IT_U = 2'd1, IT_J = 2'd2, IT_B = 2'd3;
    localparam logic [1:0] SH_L = 2'd0, SH_R = 2'd1, SH_A = 2'd2;
    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    function automatic logic [XLEN-1:0] shift_op(input logic [1:0] kind, input logic [XLEN-1:0] a,
                                                 input logic [4:0] amt);
        case (kind)
            SH_L:    return a << amt;
            SH_R:    return a >> amt;
            default: return $signed(a) >>> amt;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [XLEN-1:0]  sh_val_q, sh_val_d;
    logic [4:0]       sh_rem_q, sh_rem_d;
    logic [1:0]       sh_kind_q, sh_kind_d;
    logic [TAG_W-1:0] sh_tag_q, sh_tag_d;
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_result_q, out_result_d;
    logic             out_brv_q, out_brv_d;
    logic             out_taken_q, out_taken_d;
    logic [XLEN-1:0]  out_tgt_q, out_tgt_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic             is_i, is_u, is_j, is_b, s;
    logic [XLEN-1:0]  imm, opr2, alu_res, br_tgt, step_val;
    logic             alu_brv, alu_taken, is_shift, go_serial;
    logic [1:0]       sh_kind;
    logic [4:0]       shamt, step_amt;

    always_comb begin
        is_i = (in_imm_type == IT_I);
        is_u = (in_imm_type == IT_U);
        is_j = (in_imm_type == IT_J);
        is_b = (in_imm_type == IT_B);
        s    = in_packed_imm[19];
        imm        = '0;
        imm[31]    = s;
        imm[30:20] = is_u ? in_packed_imm[18:8] : {11{s}};
        imm[19:12] = (is_u || is_j) ? in_packed_imm[7:0] : {8{s}};
        imm[11]    = is_u ? 1'b0 : ((is_j || is_b) ? in_packed_imm[8] : s);
        imm[10:1]  = is_u ? 10'd0 : in_packed_imm[18:9];
        imm[0]     = is_i ? in_packed_imm[8] : 1'b0;

        opr2  = ((in_uop >= U_ADDI) && (in_uop <= U_SRAI)) ? imm : in_rs2;
        shamt = opr2[4:0];

        alu_res   = imm;
        alu_brv   = 1'b0;
        alu_taken = 1'b0;
        br_tgt    = in_pc + imm;
        is_shift  = 1'b0;
        sh_kind   = SH_L;
        case (in_uop)
            U_LUI:          alu_res = imm;
            U_AUIPC:        alu_res = in_pc + imm;
            U_ADDI, U_ADD:  alu_res = in_rs1 + opr2;
            U_SUB:          alu_res = in_rs1 - in_rs2;
            U_SLTI, U_SLT:  alu_res = XLEN'($signed(in_rs1) < $signed(opr2));
            U_SLTIU, U_SLTU: alu_res = XLEN'(in_rs1 < opr2);
            U_XORI, U_XOR:  alu_res = in_rs1 ^ opr2;
            U_ORI, U_OR:    alu_res = in_rs1 | opr2;
            U_ANDI, U_AND:  alu_res = in_rs1 & opr2;
            U_SLLI, U_SLL:  begin is_shift = 1'b1; sh_kind = SH_L; end
            U_SRLI, U_SRL:  begin is_shift = 1'b1; sh_kind = SH_R; end
            U_SRAI, U_SRA:  begin is_shift = 1'b1; sh_kind = SH_A; end
            U_BEQ, U_BNE, U_BLT, U_BGE, U_BLTU, U_BGEU: begin
                alu_brv = 1'b1;
                alu_res = br_tgt;
                case (in_uop)
                    U_BEQ:   alu_taken = (in_rs1 == in_rs2);
                    U_BNE:   alu_taken = (in_rs1 != in_rs2);
                    U_BLT:   alu_taken = ($signed(in_rs1) < $signed(in_rs2));
                    U_BGE:   alu_taken = ($signed(in_rs1) >= $signed(in_rs2));
                    U_BLTU:  alu_taken = (in_rs1 < in_rs2);
                    default: alu_taken = (in_rs1 >= in_rs2);
                endcase
            end
            U_JALR: begin
                alu_brv   = 1'b1;
                alu_taken = 1'b1;
                alu_res   = in_pc + XLEN'(4);
                br_tgt    = (in_rs1 + imm) & {{(XLEN-1){1'b1}}, 1'b0};
            end
            default: ;
        endcase
        if (is_shift) alu_res = shift_op(sh_kind, in_rs1, shamt);
        // A zero shift amount completes in one cycle even on the serial build.
        go_serial = (SHIFT_SERIAL != 0) && is_shift && (shamt != 5'd0);
    end

    always_comb begin
        state_d      = state_q;
        sh_val_d     = sh_val_q;
        sh_rem_d     = sh_rem_q;
        sh_kind_d    = sh_kind_q;
        sh_tag_d     = sh_tag_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_brv_d    = out_brv_q;
        out_taken_d  = out_taken_q;
        out_tgt_d    = out_tgt_q;
        out_tag_d    = out_tag_q;
        in_ready = (state_q == S_IDLE) && !flush && (!out_valid_q || out_ready);
        step_amt = (sh_rem_q < STEP) ? sh_rem_q : STEP;
        step_val = shift_op(sh_kind_q, sh_val_q, step_amt);

        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
        end else if (state_q == S_SHIFT) begin
            // The output register was free on entry, so completion can always load it.
            if (sh_rem_q <= STEP) begin
                state_d      = S_IDLE;
                out_valid_d  = 1'b1;
                out_result_d = step_val;
                out_brv_d    = 1'b0;
                out_taken_d  = 1'b0;
                out_tag_d    = sh_tag_q;
            end else begin
                sh_rem_d = sh_rem_q - STEP;
                sh_val_d = step_val;
            end
        end else if (in_valid && in_ready) begin
            if (go_serial) begin
                state_d   = S_SHIFT;
                sh_val_d  = in_rs1;
                sh_rem_d  = shamt;
                sh_kind_d = sh_kind;
                sh_tag_d  = in_tag;
            end else begin
                out_valid_d  = 1'b1;
                out_result_d = alu_res;
                out_brv_d    = alu_brv;
                out_taken_d  = alu_taken;
                out_tgt_d    = br_tgt;
                out_tag_d    = in_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sh_val_q     <= '0;
            sh_rem_q     <= '0;
            sh_kind_q    <= '0;
            sh_tag_q     <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_brv_q    <= 1'b0;
            out_taken_q  <= 1'b0;
            out_tgt_q    <= '0;
            out_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            sh_val_q     <= sh_val_d;
            sh_rem_q     <= sh_rem_d;
            sh_kind_q    <= sh_kind_d;
            sh_tag_q     <= sh_tag_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_brv_q    <= out_brv_d;
            out_taken_q  <= out_taken_d;
            out_tgt_q    <= out_tgt_d;
            out_tag_q    <= out_tag_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_result    = out_result_q;
    assign out_br_valid  = out_brv_q;
    assign out_br_taken  = out_taken_q;
    assign out_br_target = out_tgt_q;
    assign out_tag       = out_tag_q;
endmodule

// File: tb/tb_exe_pipe_unit.sv
// Bench for exe_pipe_unit built with a 4-bit/cycle serial shifter: queue-based reference model checked
// every cycle, plus directed vectors with hand-computed results.
module tb_exe_pipe_unit;
    localparam int SER = 1;
    localparam int STEP = 4;
    localparam int U_LUI = 0,  U_AUIPC = 1, U_ADDI = 2,  U_SLTI = 3,  U_SLTIU = 4, U_XORI = 5;
    localparam int U_ORI = 6,  U_ANDI = 7,  U_SLLI = 8,  U_SRLI = 9,  U_SRAI = 10, U_ADD = 11;
    localparam int U_SUB = 12, U_SLL = 13,  U_SLT = 14,  U_SLTU = 15, U_XOR = 16,  U_SRL = 17;
    localparam int U_SRA = 18, U_OR = 19,   U_AND = 20,  U_BEQ = 21,  U_BNE = 22,  U_BLT = 23;
    localparam int U_BGE = 24, U_BLTU = 25, U_BGEU = 26, U_JALR = 27;
    localparam logic [1:0] IT_I = 2'd0, IT_U = 2'd1, IT_J = 2'd2, IT_B = 2'd3;

    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, out_br_valid, out_br_taken;
    logic [4:0]  in_uop = '0;
    logic [1:0]  in_imm_type = '0;
    logic [19:0] in_packed_imm = '0;
    logic [31:0] in_pc = '0, in_rs1 = '0, in_rs2 = '0;
    logic [5:0]  in_tag = '0, out_tag;
    logic [31:0] out_result, out_br_target;

    exe_pipe_unit #(.XLEN(32), .TAG_W(6), .SHIFT_SERIAL(SER), .SHIFT_STEP(STEP)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_uop(in_uop), .in_imm_type(in_imm_type), .in_packed_imm(in_packed_imm),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_br_valid(out_br_valid), .out_br_taken(out_br_taken),
        .out_br_target(out_br_target), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        brv;
        logic        taken;
        logic [31:0] tgt;
        logic [5:0]  tag;
        int          due;
        bit          ser;
    } exp_t;

    int   checks = 0, errors = 0, cyc = 0, tagc = 1;
    exp_t q[$];
    exp_t e;
    bit   ev, er, busy;
    bit   rdy_rand = 1'b0;
    logic rdy_set = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: immediate built from its field layout, result by plain arithmetic, latency from shift count.
    function automatic exp_t model(input int uop, input logic [1:0] it, input logic [19:0] p,
                                   input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                                   input logic [5:0] tag);
        exp_t r;
        logic [31:0] imm, b;
        int sh;
        bit shop;
        case (it)
            IT_U:    imm = {p, 12'h000};
            IT_J:    imm = {{11{p[19]}}, p[19], p[7:0], p[8], p[18:9], 1'b0};
            IT_B:    imm = {{19{p[19]}}, p[19], p[8], p[18:9], 1'b0};
            default: imm = {{20{p[19]}}, p[19:8]};
        endcase
        b = (uop >= U_ADDI && uop <= U_SRAI) ? imm : rs2;
        sh = int'(b[4:0]);
        shop = 1'b0;
        r.res = imm; r.brv = 1'b0; r.taken = 1'b0; r.tgt = pc + imm; r.tag = tag;
        case (uop)
            U_AUIPC:         r.res = pc + imm;
            U_ADDI, U_ADD:   r.res = rs1 + b;
            U_SUB:           r.res = rs1 - rs2;
            U_SLTI, U_SLT:   r.res = ($signed(rs1) < $signed(b)) ? 32'd1 : 32'd0;
            U_SLTIU, U_SLTU: r.res = (rs1 < b) ? 32'd1 : 32'd0;
            U_XORI, U_XOR:   r.res = rs1 ^ b;
            U_ORI, U_OR:     r.res = rs1 | b;
            U_ANDI, U_AND:   r.res = rs1 & b;
            U_SLLI, U_SLL:   begin r.res = rs1 << sh; shop = 1'b1; end
            U_SRLI, U_SRL:   begin r.res = rs1 >> sh; shop = 1'b1; end
            U_SRAI, U_SRA:   begin r.res = $signed(rs1) >>> sh; shop = 1'b1; end
            U_BEQ:  begin r.brv = 1'b1; r.taken = (rs1 == rs2); end
            U_BNE:  begin r.brv = 1'b1; r.taken = (rs1 != rs2); end
            U_BLT:  begin r.brv = 1'b1; r.taken = ($signed(rs1) < $signed(rs2)); end
            U_BGE:  begin r.brv = 1'b1; r.taken = ($signed(rs1) >= $signed(rs2)); end
            U_BLTU: begin r.brv = 1'b1; r.taken = (rs1 < rs2); end
            U_BGEU: begin r.brv = 1'b1; r.taken = (rs1 >= rs2); end
            U_JALR: begin r.brv = 1'b1; r.taken = 1'b1; r.res = pc + 32'd4; r.tgt = (rs1 + imm) & 32'hFFFF_FFFE; end
            default: ;
        endcase
        if (r.brv && uop != U_JALR) r.res = r.tgt;
        r.ser = (SER != 0) && shop && (sh != 0);
        r.due = r.ser ? (sh + STEP - 1) / STEP + 1 : 1;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            ev = (q.size() > 0) && (q[0].due <= cyc);
            busy = 1'b0;
            foreach (q[i]) if (q[i].ser && cyc < q[i].due) busy = 1'b1;
            er = !busy && !flush && (!ev || out_ready);
            chk("in_ready", 32'(in_ready), 32'(er));
            chk("out_valid", 32'(out_valid), 32'(ev));
            if (ev && out_valid) begin
                chk("result", out_result, q[0].res);
                chk("br_valid", 32'(out_br_valid), 32'(q[0].brv));
                chk("br_taken", 32'(out_br_taken), 32'(q[0].taken));
                chk("tag", 32'(out_tag), 32'(q[0].tag));
                if (q[0].brv) chk("br_target", out_br_target, q[0].tgt);
            end
            if (flush) begin
                q.delete();
            end else begin
                if (ev && out_ready) void'(q.pop_front());
                if (in_valid && er) begin
                    e = model(int'(in_uop), in_imm_type, in_packed_imm, in_pc, in_rs1, in_rs2, in_tag);
                    e.due = e.due + cyc;
                    q.push_back(e);
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_set;
    end

    task automatic drive(input int uop, input logic [1:0] it, input logic [19:0] p, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [5:0] tag);
        in_valid = 1'b1; in_uop = 5'(uop); in_imm_type = it; in_packed_imm = p;
        in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_tag = tag;
    endtask

    task automatic send(input int uop, input logic [1:0] it, input logic [19:0] p, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [5:0] tag);
        bit ok;
        ok = 1'b0;
        drive(uop, it, p, pc, rs1, rs2, tag);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 100 cycles (uop %0d)", uop);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic lit(input string name, input int uop, input logic [1:0] it, input logic [19:0] p,
                       input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                       input int exp_lat, input logic [31:0] exp_res, input logic exp_brv,
                       input logic exp_taken, input logic [31:0] exp_tgt);
        int lat;
        lat = 0;
        send(uop, it, p, pc, rs1, rs2, 6'(tagc));
        tagc++;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (out_valid) begin lat = k; break; end
        end
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_result"}, out_result, exp_res);
        chk({name, "_br_valid"}, 32'(out_br_valid), 32'(exp_brv));
        chk({name, "_br_taken"}, 32'(out_br_taken), 32'(exp_taken));
        if (exp_brv) chk({name, "_br_target"}, out_br_target, exp_tgt);
        @(posedge clk); #1;
    endtask

    task automatic reset_state(input string name);
        chk({name, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_out_result"}, out_result, 32'd0);
        chk({name, "_br_valid"}, 32'(out_br_valid), 32'd0);
        chk({name, "_br_taken"}, 32'(out_br_taken), 32'd0);
        chk({name, "_br_target"}, out_br_target, 32'd0);
        chk({name, "_tag"}, 32'(out_tag), 32'd0);
        chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        reset_state("reset");
        @(posedge clk); #1;

        lit("addi",   U_ADDI,  IT_I, 20'hFFF00, 32'h0,   32'd5,        32'd0,        1, 32'd4,        1'b0, 1'b0, 32'h0);
        lit("lui",    U_LUI,   IT_U, 20'hABCDE, 32'h0,   32'h0,        32'h0,        1, 32'hABCDE000, 1'b0, 1'b0, 32'h0);
        lit("auipc",  U_AUIPC, IT_U, 20'hABCDE, 32'h100, 32'h0,        32'h0,        1, 32'hABCDE100, 1'b0, 1'b0, 32'h0);
        lit("sra31",  U_SRA,   IT_I, 20'h00000, 32'h0,   32'h80000000, 32'd31,       9, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0);
        lit("bltu",   U_BLTU,  IT_B, 20'h00800, 32'h40,  32'd1,        32'hFFFFFFFF, 1, 32'h48,       1'b1, 1'b1, 32'h48);
        lit("blt",    U_BLT,   IT_B, 20'h00800, 32'h40,  32'd1,        32'hFFFFFFFF, 1, 32'h48,       1'b1, 1'b0, 32'h48);
        lit("bge_neg", U_BGE,  IT_B, 20'hFFD00, 32'h100, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFC,       1'b1, 1'b1, 32'hFC);
        lit("jalr",   U_JALR,  IT_I, 20'h00200, 32'h200, 32'h1001,     32'h0,        1, 32'h204,      1'b1, 1'b1, 32'h1002);
        lit("slli5",  U_SLLI,  IT_I, 20'h00500, 32'h0,   32'd1,        32'h0,        3, 32'h20,       1'b0, 1'b0, 32'h0);
        lit("srl0",   U_SRL,   IT_I, 20'h00000, 32'h0,   32'h1234,     32'h20,       1, 32'h1234,     1'b0, 1'b0, 32'h0);
        lit("unknown", 30,     IT_U, 20'h12345, 32'h0,   32'h5,        32'h6,        1, 32'h12345000, 1'b0, 1'b0, 32'h0);

        // Held result under backpressure, then accept-and-drain in the same cycle.
        rdy_set = 1'b0;
        send(U_ADD, IT_I, 20'h0, 32'h0, 32'd7, 32'd8, 6'd40);
        drive(U_SUB, IT_I, 20'h0, 32'h0, 32'd3, 32'd5, 6'd41);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_result", out_result, 32'd15);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        rdy_set = 1'b1;
        @(negedge clk);
        chk("drain_accept_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain_new_result", out_result, 32'hFFFFFFFE);
        @(posedge clk); #1;

        // Flush a held result while a new op is offered in the flush cycle.
        rdy_set = 1'b0;
        send(U_XOR, IT_I, 20'h0, 32'h0, 32'hF0F0, 32'h0FF0, 6'd42);
        drive(U_ADD, IT_I, 20'h0, 32'h0, 32'd1, 32'd1, 6'd43);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; rdy_set = 1'b1;
        @(negedge clk);
        chk("flush_held_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Flush in the middle of a serial shift.
        send(U_SRAI, IT_I, 20'h01400, 32'h0, 32'hF0000000, 32'h0, 6'd44);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_shift_valid", 32'(out_valid), 32'd0);
        chk("flush_shift_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Mixed stream with random consumer backpressure, checked by the model.
        rdy_rand = 1'b1;
        for (int n = 0; n < 60; n++) begin
            send($urandom_range(0, 31), 2'($urandom_range(0, 3)), 20'($urandom), $urandom,
                 (n % 4 == 0) ? 32'h80000001 : $urandom, (n % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                 6'($urandom));
        end
        rdy_rand = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // Reset while a shift is in flight clears the stale output data.
        lit("lui_pre_rst", U_LUI, IT_U, 20'hABCDE, 32'h0, 32'h0, 32'h0, 1, 32'hABCDE000, 1'b0, 1'b0, 32'h0);
        send(U_SLL, IT_I, 20'h0, 32'h0, 32'd1, 32'd31, 6'd45);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        reset_state("rst_mid_shift");
        repeat (12) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: run still active at time %0t, expected completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
